// File: rtl/manchester_pkg.sv
// manchester_pkg: scheduler state encoding and default framing bytes shared by manchester link blocks
package manchester_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, SOF, PAYLOAD, GAP} state_t;
    localparam logic [7:0] DEF_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] DEF_SOF_BYTE = 8'hD5;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, wrapping
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);
    always_comb begin
        any = |req;
        idx = '0;
        // descending scan so the request closest to ptr is assigned last and wins
        for (int k = N - 1; k >= 0; k--) begin
            logic [W-1:0] j;
            j = W'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
    end
endmodule

// File: rtl/manchester_frame_scheduler.sv
// manchester_frame_scheduler: grants whole frames round-robin to NUM_SRC byte sources and wraps
// each in preamble + SOF ahead of the serializer, followed by a fixed idle gap
module manchester_frame_scheduler
    import manchester_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int PREAMBLE_LEN = 4,
    parameter logic [7:0] PREAMBLE_BYTE = DEF_PREAMBLE_BYTE,
    parameter logic [7:0] SOF_BYTE = DEF_SOF_BYTE,
    parameter int IFG_CYCLES = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       enable,
    input  logic [NUM_SRC*8-1:0]       s_axis_tdata,
    input  logic [NUM_SRC-1:0]         s_axis_tvalid,
    input  logic [NUM_SRC-1:0]         s_axis_tlast,
    output logic [NUM_SRC-1:0]         s_axis_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       busy,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       frame_done
);
    localparam int IW = $clog2(NUM_SRC);

    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [IW-1:0] rr_ptr, rr_ptr_n, grant_n, pick;
    logic any_req, last_hs;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req(s_axis_tvalid),
        .ptr(rr_ptr),
        .any(any_req),
        .idx(pick)
    );

    assign last_hs = state == PAYLOAD && s_axis_tvalid[grant_idx] && m_axis_tready && s_axis_tlast[grant_idx];
    assign frame_done = last_hs;
    assign busy = state != IDLE;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
            cnt <= '0;
            rr_ptr <= '0;
            grant_idx <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            rr_ptr <= rr_ptr_n;
            grant_idx <= grant_n;
        end
    end

    // cnt counts preamble handshakes, then is reused as the inter-frame gap countdown
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        rr_ptr_n = rr_ptr;
        grant_n = grant_idx;
        m_axis_tvalid = 1'b0;
        m_axis_tdata = '0;
        s_axis_tready = '0;
        case (state)
            IDLE: begin
                if (enable && any_req) begin
                    grant_n = pick;
                    cnt_n = '0;
                    state_n = PREAMBLE;
                end
            end
            PREAMBLE: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata = PREAMBLE_BYTE;
                if (m_axis_tready) begin
                    cnt_n = cnt + 8'd1;
                    if (cnt == 8'(PREAMBLE_LEN - 1)) state_n = SOF;
                end
            end
            SOF: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata = SOF_BYTE;
                if (m_axis_tready) state_n = PAYLOAD;
            end
            PAYLOAD: begin
                m_axis_tvalid = s_axis_tvalid[grant_idx];
                m_axis_tdata = s_axis_tdata[8*grant_idx +: 8];
                s_axis_tready[grant_idx] = m_axis_tready;
                if (last_hs) begin
                    rr_ptr_n = grant_idx == IW'(NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
                    cnt_n = 8'(IFG_CYCLES);
                    state_n = IFG_CYCLES == 0 ? IDLE : GAP;
                end
            end
            GAP: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_manchester_frame_scheduler.sv
// tb_manchester_frame_scheduler: scoreboard bench; a frame-level round-robin model queues expected
// bytes, a monitor pops and compares on every serializer handshake
module tb_manchester_frame_scheduler;
    localparam int N = 4;
    localparam int PL = 4;
    localparam int IFG = 32;
    localparam logic [7:0] PB = 8'h55;
    localparam logic [7:0] SB = 8'hD5;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic enable = 1'b1;
    logic [N*8-1:0] s_axis_tdata = '0;
    logic [N-1:0] s_axis_tvalid = '0;
    logic [N-1:0] s_axis_tlast = '0;
    logic [N-1:0] s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic m_axis_tvalid;
    logic m_axis_tready = 1'b0;
    logic busy;
    logic [$clog2(N)-1:0] grant_idx;
    logic frame_done;

    typedef struct {
        logic [7:0] data;
        bit last;
        bit pay;
        int src;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] sd[N][$];
    bit sl[N][$];
    logic [7:0] ud[N][$];
    bit ul[N][$];
    int uf[N];
    bit mid[N];
    int gap_left[N];
    int gap_arm[N];
    int mptr = 0;
    int cyc = 0;
    int cmps = 0;
    int errs = 0;
    int stall = 0;
    int rdy_mode = 0;
    bit rnd_gaps = 1'b0;

    manchester_frame_scheduler #(
        .NUM_SRC(N), .PREAMBLE_LEN(PL), .PREAMBLE_BYTE(PB), .SOF_BYTE(SB), .IFG_CYCLES(IFG)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .busy(busy), .grant_idx(grant_idx), .frame_done(frame_done)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        cmps++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge aclk);
            #3;
        end
    endtask

    // frame of len bytes taken MSB-first from w
    task automatic load(int s, logic [31:0] w, int len);
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = w[8*(len-1-k) +: 8];
            sd[s].push_back(b);
            sl[s].push_back(k == len - 1);
            ud[s].push_back(b);
            ul[s].push_back(k == len - 1);
        end
        uf[s]++;
    endtask

    // reference: every source with a pending frame is requesting, so frames leave in round-robin order
    function automatic void schedule();
        exp_t e;
        int j;
        while (1) begin
            j = -1;
            for (int k = 0; k < N; k++) if (j < 0 && uf[(mptr + k) % N] > 0) j = (mptr + k) % N;
            if (j < 0) break;
            e = '{data: PB, last: 1'b0, pay: 1'b0, src: j};
            repeat (PL) exp_q.push_back(e);
            e.data = SB;
            exp_q.push_back(e);
            e.pay = 1'b1;
            do begin
                e.data = ud[j].pop_front();
                e.last = ul[j].pop_front();
                exp_q.push_back(e);
            end while (!e.last);
            uf[j]--;
            mptr = (j + 1) % N;
        end
    endfunction

    task automatic drain(int budget);
        int n = 0;
        while ((exp_q.size() > 0 || busy) && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    task automatic quiet_cycles(string nm, int len);
        int n = 0;
        repeat (len) begin
            tick(1);
            if (busy || m_axis_tvalid) n++;
        end
        chk(nm, n, 0);
    endtask

    // source and serializer driver
    initial forever begin
        @(negedge aclk);
        m_axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 16 == 0) : ($urandom_range(0, 9) < 7);
        for (int i = 0; i < N; i++) begin
            bit v;
            v = sd[i].size() > 0;
            if (v && mid[i] && gap_left[i] > 0) begin
                v = 1'b0;
                gap_left[i]--;
            end else if (v && mid[i] && rnd_gaps && $urandom_range(0, 3) == 0) v = 1'b0;
            s_axis_tvalid[i] = v;
            s_axis_tdata[8*i +: 8] = sd[i].size() > 0 ? sd[i][0] : 8'($urandom);
            s_axis_tlast[i] = sd[i].size() > 0 ? sl[i][0] : 1'($urandom);
        end
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_axis_tvalid[i] && s_axis_tready[i]) begin
                void'(sd[i].pop_front());
                mid[i] = !sl[i].pop_front();
                if (mid[i] && gap_arm[i] > 0) begin
                    gap_left[i] = gap_arm[i];
                    gap_arm[i] = 0;
                end
            end
        end
    end

    // monitor
    initial begin
        exp_t e;
        bit hp, hold, barm, varm, exact;
        logic [7:0] hold_d;
        int done_c;
        hold = 0; barm = 0; varm = 0; exact = 0; hold_d = 0; done_c = 0;
        forever begin
            @(negedge aclk);
            #2;
            if (!aresetn) begin
                hold = 0;
                barm = 0;
                varm = 0;
            end else begin
                hp = exp_q.size() > 0 && exp_q[0].pay;
                if (hold) chk("hold_stable", {m_axis_tvalid, m_axis_tdata}, {1'b1, hold_d});
                hold = m_axis_tvalid && !m_axis_tready && !hp;
                hold_d = m_axis_tdata;
                if (!m_axis_tvalid && !hp) chk("idle_tdata", m_axis_tdata, 0);
                if (!m_axis_tvalid && hp) stall++;
                if (|s_axis_tready) chk("s_tready", s_axis_tready, hp ? (1 << exp_q[0].src) : 0);
                if (barm && !busy) begin
                    chk("gap_to_idle", cyc - done_c, IFG + 1);
                    barm = 0;
                end
                if (varm && m_axis_tvalid) begin
                    if (exact) chk("gap_to_next", cyc - done_c, IFG + 2);
                    else chk("gap_min", (cyc - done_c) >= IFG + 2, 1);
                    varm = 0;
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        cmps++;
                        errs++;
                        $display("FAIL extra_byte: got %0h expected none (cycle %0d)", m_axis_tdata, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", m_axis_tdata, e.data);
                        chk("frame_done", frame_done, e.last);
                        if (e.last) begin
                            chk("grant_idx", grant_idx, e.src);
                            done_c = cyc;
                            barm = 1;
                            varm = 1;
                            exact = exp_q.size() > 0;
                        end
                    end
                end else if (frame_done) chk("stray_done", frame_done, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0;
        tick(3);
        aresetn = 1'b1;
        tick(1);
        chk("rst_busy", busy, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_done", frame_done, 0);

        load(0, 32'hA1A2, 2);
        schedule();
        drain(400);

        load(1, 32'h11, 1);
        load(1, 32'h12, 1);
        load(3, 32'h31, 1);
        load(3, 32'h32, 1);
        schedule();
        drain(800);

        rdy_mode = 1;
        load(0, 32'hA1A2, 2);
        schedule();
        drain(1000);
        rdy_mode = 0;

        gap_arm[2] = 5;
        load(2, 32'hB1B2B3, 3);
        schedule();
        s0 = stall;
        drain(400);
        chk("src_gap_stall", stall - s0, 5);

        enable = 1'b0;
        load(1, 32'hC1, 1);
        quiet_cycles("enable_low_idle", 20);
        enable = 1'b1;
        schedule();
        drain(400);

        load(1, 32'hD1D2D3D4, 4);
        schedule();
        n = 0;
        while (!(exp_q.size() > 0 && exp_q[0].pay) && n < 100) begin
            tick(1);
            n++;
        end
        chk("reach_payload", n < 100, 1);
        load(3, 32'hE1, 1);
        enable = 1'b0;
        drain(400);
        quiet_cycles("no_grant_after_disable", 40);
        enable = 1'b1;
        schedule();
        drain(400);

        load(1, 32'hF1, 1);
        schedule();
        drain(400);
        load(2, 32'h6162, 2);
        schedule();
        n = 0;
        while (!(m_axis_tvalid && m_axis_tdata == SB) && n < 100) begin
            tick(1);
            n++;
        end
        chk("reach_sof", n < 100, 1);
        aresetn = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            sd[i].delete();
            sl[i].delete();
            ud[i].delete();
            ul[i].delete();
            uf[i] = 0;
            mid[i] = 0;
            gap_left[i] = 0;
        end
        mptr = 0;
        tick(1);
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant_idx, 0);
        chk("abort_tready", s_axis_tready, 0);
        aresetn = 1'b1;
        load(2, 32'h71, 1);
        load(0, 32'h70, 1);
        schedule();
        drain(400);

        rdy_mode = 2;
        rnd_gaps = 1'b1;
        repeat (3) begin
            for (int s = 0; s < N; s++) repeat ($urandom_range(0, 3)) load(s, $urandom, $urandom_range(1, 4));
            schedule();
            drain(8000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
